// File: rtl/reg_bank_write_arbiter_if.sv
// Write-request bus between requesters and reg_bank_write_arbiter, plus the
// bank-side En/D lines it drives.
interface reg_bank_write_arbiter_if #(
  parameter int unsigned N    = 8,
  parameter int unsigned NREG = 4,
  parameter int unsigned AW   = 2,
  parameter int unsigned NREQ = 4
);
  logic [NREQ-1:0]    Req;
  logic [NREQ*AW-1:0] ReqAddr;
  logic [NREQ*N-1:0]  ReqData;
  logic [NREQ-1:0]    Lock;
  logic [NREQ-1:0]    Gnt;
  logic [NREQ-1:0]    Ack;
  logic               AddrErr;
  logic [NREG-1:0]    RegEn;
  logic [N-1:0]       RegD;
  logic               Busy;

  modport master (
    output Req, ReqAddr, ReqData, Lock,
    input  Gnt, Ack, AddrErr, RegEn, RegD, Busy
  );

  modport slave (
    input  Req, ReqAddr, ReqData, Lock,
    output Gnt, Ack, AddrErr, RegEn, RegD, Busy
  );
endinterface

// File: rtl/reg_bank_write_arbiter.sv
// Round-robin write arbiter/sequencer for a bank of nBitDRegister cells.
// Optional lock bursts (up to 4 writes per grant) enabled by REG_ARB_LOCK_EN.
module reg_bank_write_arbiter #(
  parameter int unsigned N    = 8,
  parameter int unsigned NREG = 4,
  parameter int unsigned AW   = 2,
  parameter int unsigned NREQ = 4
) (
  input logic                     Clk,
  input logic                     R,
  reg_bank_write_arbiter_if.slave bus
);

  localparam int unsigned WW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {
    IDLE,
    WRITE
  } state_t;

  state_t         state;
  logic           armed;
  logic [WW-1:0]  last_w;
  logic [WW-1:0]  cur_w;
  logic [AW-1:0]  cap_addr;
  logic [N-1:0]   cap_data;
  logic           addr_bad;

  logic           rr_found;
  logic [WW-1:0]  rr_w;
  logic [WW-1:0]  sel_w;
  logic [AW-1:0]  sel_addr;
  logic [N-1:0]   sel_data;

`ifdef REG_ARB_LOCK_EN
  logic [1:0]     burst_cnt;
`else
  logic           unused_lock;
  assign unused_lock = ^bus.Lock;
`endif

  assign addr_bad = (32'(cap_addr) >= NREG);

  // Search starts one past the last winner so every requester gets a turn.
  always_comb begin
    logic [WW-1:0] idx;
    rr_found = 1'b0;
    rr_w     = '0;
    idx      = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      idx = WW'((32'(last_w) + k) % NREQ);
      if (!rr_found && bus.Req[idx]) begin
        rr_found = 1'b1;
        rr_w     = idx;
      end
    end
  end

  // In WRITE the only capture is a lock continuation from the current owner.
  assign sel_w = (state == WRITE) ? cur_w : rr_w;

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (sel_w == WW'(i)) begin
        sel_addr = bus.ReqAddr[i*AW +: AW];
        sel_data = bus.ReqData[i*N +: N];
      end
    end
  end

  always_ff @(posedge Clk or negedge R) begin
    if (!R) begin
      state       <= IDLE;
      armed       <= 1'b0;
      last_w      <= WW'(NREQ - 1);
      cur_w       <= '0;
      cap_addr    <= '0;
      cap_data    <= '0;
      bus.Gnt     <= '0;
      bus.Ack     <= '0;
      bus.AddrErr <= 1'b0;
      bus.Busy    <= 1'b0;
`ifdef REG_ARB_LOCK_EN
      burst_cnt   <= '0;
`endif
    end else begin
      armed       <= 1'b1;
      bus.Ack     <= '0;
      bus.AddrErr <= 1'b0;
      case (state)
        IDLE: begin
          if (armed && rr_found) begin
            state    <= WRITE;
            bus.Busy <= 1'b1;
            cur_w    <= rr_w;
            last_w   <= rr_w;
            cap_addr <= sel_addr;
            cap_data <= sel_data;
            bus.Gnt  <= NREQ'(1) << rr_w;
`ifdef REG_ARB_LOCK_EN
            burst_cnt <= '0;
`endif
          end
        end
        WRITE: begin
          bus.Ack     <= bus.Gnt;
          bus.AddrErr <= addr_bad;
`ifdef REG_ARB_LOCK_EN
          if (bus.Lock[cur_w] && bus.Req[cur_w] && (burst_cnt != 2'd3)) begin
            cap_addr  <= sel_addr;
            cap_data  <= sel_data;
            burst_cnt <= burst_cnt + 2'd1;
          end else begin
            state    <= IDLE;
            bus.Gnt  <= '0;
            bus.Busy <= 1'b0;
          end
`else
          state    <= IDLE;
          bus.Gnt  <= '0;
          bus.Busy <= 1'b0;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Launched on the falling edge so En is settled before the gated clock rises.
  always_ff @(negedge Clk or negedge R) begin
    if (!R) begin
      bus.RegEn <= '0;
      bus.RegD  <= '0;
    end else if (state == WRITE) begin
      bus.RegEn <= addr_bad ? '0 : (NREG'(1) << cap_addr);
      bus.RegD  <= cap_data;
    end else begin
      bus.RegEn <= '0;
    end
  end

endmodule

// File: tb/tb_reg_bank_write_arbiter.sv
// Self-checking bench for reg_bank_write_arbiter with a gated-clock register bank model.
`timescale 1ns/1ps
module tb_reg_bank_write_arbiter;
  localparam int unsigned N    = 8;
  localparam int unsigned NREG = 4;
  localparam int unsigned AW   = 3;
  localparam int unsigned NREQ = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic bank_clr = 1'b1;
  always #5 clk = ~clk;

  reg_bank_write_arbiter_if #(.N(N), .NREG(NREG), .AW(AW), .NREQ(NREQ)) bus ();

  reg_bank_write_arbiter #(.N(N), .NREG(NREG), .AW(AW), .NREQ(NREQ)) dut (
    .Clk(clk),
    .R  (rst_n),
    .bus(bus)
  );

  // Bank of nBitDRegister cells: each clocked by Clk AND En.
  logic [N-1:0] bank [NREG];
  always @(posedge clk) begin
    for (int unsigned i = 0; i < NREG; i++) begin
      if (bank_clr) bank[i] <= '0;
      else if (bus.RegEn[i]) bank[i] <= bus.RegD;
    end
  end

  int checks = 0;
  int fails  = 0;
  logic [N-1:0] exp_bank [NREG];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_bank(input string tag);
    for (int unsigned i = 0; i < NREG; i++)
      check($sformatf("%s_bank%0d", tag, i), 32'(bank[i]), 32'(exp_bank[i]));
  endtask

  task automatic set_req(input int unsigned i, input logic [AW-1:0] a, input logic [N-1:0] d);
    bus.ReqAddr[i*AW +: AW] = a;
    bus.ReqData[i*N +: N]   = d;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.Req = '0;
    bus.Lock = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  typedef struct {
    int unsigned     rq;
    logic [AW-1:0]   addr;
    logic [N-1:0]    data;
    logic [NREG-1:0] exp_en;
    logic            exp_err;
  } vec_t;

  vec_t vecs [6];

  // Random-phase reference state
  logic            pend [NREQ];
  logic            m_busy;
  int unsigned     m_w, m_last;
  logic [AW-1:0]   m_addr;
  logic [N-1:0]    m_data;
  logic [NREQ-1:0] e_gnt, e_ack;
  logic            e_err;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acks, g0;
    int ack_at [6];
    int exp_off [6];
    int extra;

    vecs[0] = '{0, 3'd2, 8'hA5, 4'b0100, 1'b0};
    vecs[1] = '{1, 3'd0, 8'h3C, 4'b0001, 1'b0};
    vecs[2] = '{3, 3'd3, 8'h5A, 4'b1000, 1'b0};
    vecs[3] = '{2, 3'd5, 8'hEE, 4'b0000, 1'b1};
    vecs[4] = '{2, 3'd1, 8'h81, 4'b0010, 1'b0};
    vecs[5] = '{0, 3'd7, 8'h11, 4'b0000, 1'b1};

    bus.Req = '0; bus.Lock = '0; bus.ReqAddr = '0; bus.ReqData = '0;
    for (int unsigned i = 0; i < NREG; i++) exp_bank[i] = '0;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    check("rst_gnt",  32'(bus.Gnt), 0);
    check("rst_ack",  32'(bus.Ack), 0);
    check("rst_err",  32'(bus.AddrErr), 0);
    check("rst_busy", 32'(bus.Busy), 0);
    check("rst_regen",32'(bus.RegEn), 0);
    check("rst_regd", 32'(bus.RegD), 0);
    bank_clr = 1'b0;

    // First arbitration only at the second posedge after release
    bus.Req[1] = 1'b1;
    set_req(1, 3'd3, 8'h5C);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rel_gnt_edge1", 32'(bus.Gnt), 0);
    @(posedge clk); #1;
    check("rel_gnt_edge2", 32'(bus.Gnt), 32'b0010);
    @(posedge clk); #1;
    check("rel_ack", 32'(bus.Ack), 32'b0010);
    bus.Req = '0;
    @(negedge clk); #1;
    exp_bank[3] = 8'h5C;
    check_bank("rel");

    // Table-driven single-requester writes
    for (int v = 0; v < 6; v++) begin
      bus.Req[vecs[v].rq] = 1'b1;
      set_req(vecs[v].rq, vecs[v].addr, vecs[v].data);
      @(posedge clk); #1;
      check($sformatf("v%0d_gnt", v), 32'(bus.Gnt), 32'(1) << vecs[v].rq);
      check($sformatf("v%0d_busy", v), 32'(bus.Busy), 1);
      check($sformatf("v%0d_ack_early", v), 32'(bus.Ack), 0);
      @(negedge clk); #1;
      check($sformatf("v%0d_regen", v), 32'(bus.RegEn), 32'(vecs[v].exp_en));
      if (!vecs[v].exp_err)
        check($sformatf("v%0d_regd", v), 32'(bus.RegD), 32'(vecs[v].data));
      @(posedge clk); #1;
      check($sformatf("v%0d_ack", v), 32'(bus.Ack), 32'(1) << vecs[v].rq);
      check($sformatf("v%0d_err", v), 32'(bus.AddrErr), 32'(vecs[v].exp_err));
      check($sformatf("v%0d_gnt_clr", v), 32'(bus.Gnt), 0);
      bus.Req = '0;
      @(negedge clk); #1;
      check($sformatf("v%0d_regen_off", v), 32'(bus.RegEn), 0);
      if (!vecs[v].exp_err) exp_bank[vecs[v].addr] = vecs[v].data;
      check_bank($sformatf("v%0d", v));
    end

    // Round-robin with all requesters held
    do_reset();
    for (int unsigned i = 0; i < NREQ; i++) set_req(i, AW'(i), N'(8'h10 + i));
    bus.Req = '1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check($sformatf("rr%0d_gnt", k), 32'(bus.Gnt), 32'(1) << (k % 4));
      if (k == 4) bus.Req = '0;
      @(posedge clk); #1;
      check($sformatf("rr%0d_ack", k), 32'(bus.Ack), 32'(1) << (k % 4));
      check($sformatf("rr%0d_gnt_gap", k), 32'(bus.Gnt), 0);
    end
    @(negedge clk); #1;
    for (int unsigned i = 0; i < NREG; i++) exp_bank[i] = N'(8'h10 + i);
    check_bank("rr");

    // Address/data changed after grant: captured values are written
    bus.Req[1] = 1'b1;
    set_req(1, 3'd3, 8'h3C);
    @(posedge clk); #1;
    check("cap_gnt", 32'(bus.Gnt), 32'b0010);
    set_req(1, 3'd0, 8'hFF);
    @(negedge clk); #1;
    check("cap_regen", 32'(bus.RegEn), 32'b1000);
    check("cap_regd", 32'(bus.RegD), 32'h3C);
    @(posedge clk); #1;
    check("cap_ack", 32'(bus.Ack), 32'b0010);
    bus.Req = '0;
    @(negedge clk); #1;
    exp_bank[3] = 8'h3C;
    check_bank("cap");

    // Reset asserted during the grant cycle aborts the write
    bus.Req[0] = 1'b1;
    set_req(0, 3'd1, 8'h77);
    @(posedge clk); #1;
    check("rmid_gnt", 32'(bus.Gnt), 32'b0001);
    @(negedge clk); #1;
    check("rmid_regen", 32'(bus.RegEn), 32'b0010);
    rst_n = 1'b0;
    #1;
    check("rmid_regen_drop", 32'(bus.RegEn), 0);
    check("rmid_gnt_drop", 32'(bus.Gnt), 0);
    check("rmid_regd", 32'(bus.RegD), 0);
    bus.Req = '0;
    @(posedge clk); #1;
    check("rmid_no_ack", 32'(bus.Ack), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); #1;
    check_bank("rmid");

    // Lock burst: requester 2 wants 6 writes
`ifdef REG_ARB_LOCK_EN
    exp_off = '{1, 2, 3, 4, 6, 7};
`else
    exp_off = '{1, 3, 5, 7, 9, 11};
`endif
    do_reset();
    acks = 0; g0 = -1;
    for (int j = 0; j < 6; j++) ack_at[j] = -100;
    bus.Req[2] = 1'b1; bus.Lock[2] = 1'b1;
    set_req(2, 3'd2, 8'h40);
    for (int c = 0; c < 40 && acks < 6; c++) begin
      @(posedge clk); #1;
      if (bus.Gnt[2] && g0 < 0) g0 = c;
      if (bus.Ack[2]) begin
        ack_at[acks] = c;
        acks++;
      end
      if (acks + (bus.Gnt[2] ? 1 : 0) >= 6) begin
        bus.Req[2] = 1'b0; bus.Lock[2] = 1'b0;
      end
      set_req(2, AW'(c % NREG), N'(8'h40 + c));
    end
    bus.Req = '0; bus.Lock = '0;
    check("lock_ack_count", 32'(acks), 6);
    for (int j = 0; j < 6; j++)
      check($sformatf("lock_ack%0d_off", j), 32'(ack_at[j] - g0), 32'(exp_off[j]));
    extra = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (bus.Ack != '0) extra++;
    end
    check("lock_no_extra_ack", 32'(extra), 0);
    check("lock_idle_busy", 32'(bus.Busy), 0);
    @(negedge clk);
    for (int unsigned i = 0; i < NREG; i++) exp_bank[i] = bank[i];

    // Randomized traffic against a transaction-level reference
    do_reset();
    m_busy = 1'b0; m_last = NREQ - 1; m_w = 0; m_addr = '0; m_data = '0;
    for (int unsigned i = 0; i < NREQ; i++) pend[i] = 1'b0;
    for (int c = 0; c < 300; c++) begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i] = 1'b1;
          set_req(i, AW'($urandom_range(0, 7)), N'($urandom));
        end else if (pend[i] && m_busy && m_w == i) begin
          set_req(i, AW'($urandom_range(0, 7)), N'($urandom));
        end
        bus.Req[i] = pend[i];
      end
      e_ack = '0; e_err = 1'b0; e_gnt = '0;
      if (m_busy) begin
        e_ack = NREQ'(1) << m_w;
        e_err = (32'(m_addr) >= NREG);
        if (!e_err) exp_bank[m_addr[1:0]] = m_data;
        pend[m_w] = 1'b0;
        m_busy = 1'b0;
      end else begin
        for (int unsigned k = 1; k <= NREQ && !m_busy; k++) begin
          int unsigned j;
          j = (m_last + k) % NREQ;
          if (bus.Req[j]) begin
            m_busy = 1'b1; m_w = j; m_last = j;
            m_addr = bus.ReqAddr[j*AW +: AW];
            m_data = bus.ReqData[j*N +: N];
            e_gnt  = NREQ'(1) << j;
          end
        end
      end
      @(posedge clk); #1;
      check($sformatf("rnd%0d_gnt", c), 32'(bus.Gnt), 32'(e_gnt));
      check($sformatf("rnd%0d_ack", c), 32'(bus.Ack), 32'(e_ack));
      check($sformatf("rnd%0d_err", c), 32'(bus.AddrErr), 32'(e_err));
      check($sformatf("rnd%0d_busy", c), 32'(bus.Busy), 32'(m_busy));
      @(negedge clk); #1;
      check($sformatf("rnd%0d_regen", c), 32'(bus.RegEn),
            (m_busy && 32'(m_addr) < NREG) ? (32'(1) << m_addr) : 32'(0));
      if (m_busy && 32'(m_addr) < NREG)
        check($sformatf("rnd%0d_regd", c), 32'(bus.RegD), 32'(m_data));
      for (int unsigned i = 0; i < NREQ; i++) bus.Req[i] = pend[i];
    end
    bus.Req = '0;
    repeat (3) @(negedge clk);
    #1;
    check_bank("rnd_final");

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/reg_bank_write_arbiter.md
# reg_bank_write_arbiter

Round-robin write arbiter and sequencer for a bank of `NREG` N-bit D registers built from `nBitDRegister`. Up to `NREQ` requesters share the bank's single write path. The block does the following:
- captures each winning request's address and data;
- drives the per-register `En` lines and the shared `D` bus so that writes through the AND-gated register clocks are glitch-free;
- returns a one-cycle acknowledge per completed write.

## Interface
- `N`, 8, data width of each register
- `NREG`, 4, number of registers in the bank
- `AW`, 2, address width; must satisfy 2^AW ≥ NREG
- `NREQ`, 4, number of requesters
- `Clk`  in  1  system clock; all state except `RegEn`/`RegD` changes on the rising edge
- `R`  in  1  reset, asynchronous, active-low
- `Req`  in  NREQ  per-requester write request, level; held until `Ack`
- `ReqAddr`  in  NREQ*AW  per-requester target register; slice i is `[i*AW +: AW]`
- `ReqData`  in  NREQ*N  per-requester write data; slice i is `[i*N +: N]`
- `Lock`  in  NREQ  per-requester burst hold (used only with `REG_ARB_LOCK_EN`)
- `Gnt`  out  NREQ  one-hot grant, registered
- `Ack`  out  NREQ  one-hot, one-cycle pulse when the write has been committed
- `AddrErr`  out  1  one-cycle pulse with `Ack` when the granted address is ≥ NREG
- `RegEn`  out  NREG  one-hot register enable, to `En` of each `nBitDRegister`
- `RegD`  out  N  shared write data, to `D` of every register
- `Busy`  out  1  high while the FSM is in WRITE

## Operation
- FSM has two states:
  - IDLE: no grant outstanding.
  - WRITE: one granted write in progress.
- IDLE, any `Req` high at posedge:
  - Pick the winner by round-robin, starting at `(last_winner+1) mod NREQ`.
  - Capture the winner's address and data into internal registers.
  - Set `Gnt[w]=1` and go to WRITE.
  - Update `last_winner` to w.
- WRITE, at the next posedge:
  - Pulse `Ack[w]`.
  - Clear `Gnt`.
  - Go to IDLE, or stay in WRITE when a lock burst continues (see Configuration).
- Requester side:
  - Address and data are sampled only at the grant edge; after `Gnt` they may change.
  - `Req` dropping after the grant does not cancel the write. The write completes and `Ack` is still issued.
- Bank side:
  - `RegEn` and `RegD` are launched on the falling edge of `Clk`, so `En` is stable across the whole high phase.
  - On the negedge after the grant edge: `RegEn[addr]=1` and `RegD=data`.
  - On the negedge after the `Ack` edge: `RegEn=0`; `RegD` holds its value.
- Out-of-range address (≥ NREG):
  - No `RegEn` bit is set.
  - `Ack` and `AddrErr` pulse together.
- `Gnt`, `Ack` and `RegEn` are each zero-or-one-hot at all times.

## Timing
- Grant latency: `Gnt` is high in the cycle after `Req` is sampled.
- Write commit happens at the posedge following the grant cycle, in the same cycle `Ack` is asserted.
- Throughput without lock: one write per 2 cycles. `Req` still high in the `Ack` cycle is re-arbitrated at the next posedge in IDLE.
- Reset (`R`=0, asynchronous) drives:
  - state to IDLE;
  - `Gnt=0`, `Ack=0`, `AddrErr=0`, `Busy=0`, `RegEn=0`, `RegD=0`;
  - `last_winner=NREQ-1`, so requester 0 wins first.
- Reset in the middle of a write: `RegEn` falls immediately, the write is aborted and no `Ack` is issued.
- Reset deassertion is synchronous to the rising edge of `Clk`. The first arbitration happens at the second posedge after release.

## Configuration
- `REG_ARB_LOCK_EN` defined:
  - In WRITE, if `Lock[w]` and `Req[w]` are high at the `Ack` edge, the block captures the requester's new address and data, keeps `Gnt[w]`, and stays in WRITE.
  - This gives back-to-back writes, one per cycle, with `RegEn` re-launched on each negedge.
  - A burst is capped at 4 writes. After the 4th `Ack` the block returns to IDLE for forced re-arbitration.
- `REG_ARB_LOCK_EN` undefined: the `Lock` port exists but is ignored, and every write returns to IDLE.

## Test plan
- Reset, then `Req=0001`, addr 2, data 0xA5:
  - `Gnt=0001` next cycle;
  - `RegEn=0100` from the following negedge;
  - `Ack=0001` one cycle later;
  - register 2 reads 0xA5 and the other registers are unchanged.
- `Req=1111` held continuously, distinct addr/data per requester: grants go 0,1,2,3,0 at 2-cycle spacing, and each register holds its own requester's data.
- Requester 1 changes `ReqAddr`/`ReqData` in the cycle after its `Gnt`: the originally captured values are written.
- Addr 5 with NREG=4: `Ack` and `AddrErr` pulse together, no `RegEn` bit rises, and all registers are unchanged.
- `R` pulled low in the `Gnt` cycle: `RegEn` and `Gnt` drop immediately, there is no `Ack`, and the target register keeps its old value.
- With `REG_ARB_LOCK_EN`, requester 2 holds `Lock` and `Req` and issues 6 writes: 4 `Ack`s in consecutive cycles, then IDLE, then re-grant. Without the macro the same stimulus gives `Ack` every 2 cycles.
